// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns single cache-line read/write requests into AXI4 INCR bursts, one transaction at a time
// Ports:
//   i_clk, i_arst                 clock (rising edge), asynchronous active-low reset
//   i_read_start, i_write_start   core requests, sampled only in IDLE (write wins a tie)
//   i_addr, i_data_block          block address and write-back line
//   o_data_block, o_done, o_error refill line, one-cycle completion pulse, error flag valid with o_done
//   o_aw*/i_awready, o_w*/i_wready, i_b*/o_bready, o_ar*/i_arready, i_r*/o_rready   AXI4 master channels
module axi4_burst_master #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int AXI_DATA_W  = 32,
   parameter int AXI_ID_W    = 4
) (
   input  logic                    i_clk,
   input  logic                    i_arst,
   input  logic                    i_read_start,
   input  logic                    i_write_start,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [BLOCK_WIDTH-1:0]  i_data_block,
   output logic [BLOCK_WIDTH-1:0]  o_data_block,
   output logic                    o_done,
   output logic                    o_error,
   output logic [AXI_ID_W-1:0]     o_awid,
   output logic [ADDR_WIDTH-1:0]   o_awaddr,
   output logic [7:0]              o_awlen,
   output logic [2:0]              o_awsize,
   output logic [1:0]              o_awburst,
   output logic                    o_awvalid,
   input  logic                    i_awready,
   output logic [AXI_DATA_W-1:0]   o_wdata,
   output logic [AXI_DATA_W/8-1:0] o_wstrb,
   output logic                    o_wlast,
   output logic                    o_wvalid,
   input  logic                    i_wready,
   input  logic [1:0]              i_bresp,
   input  logic                    i_bvalid,
   output logic                    o_bready,
   output logic [AXI_ID_W-1:0]     o_arid,
   output logic [ADDR_WIDTH-1:0]   o_araddr,
   output logic [7:0]              o_arlen,
   output logic [2:0]              o_arsize,
   output logic [1:0]              o_arburst,
   output logic                    o_arvalid,
   input  logic                    i_arready,
   input  logic [AXI_DATA_W-1:0]   i_rdata,
   input  logic [1:0]              i_rresp,
   input  logic                    i_rlast,
   input  logic                    i_rvalid,
   output logic                    o_rready
);
   localparam int BEATS = BLOCK_WIDTH / AXI_DATA_W;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

   typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BLOCK_WIDTH-1:0] wbuf_q, wbuf_d, rbuf_q, rbuf_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wbuf_q    <= '0;
         rbuf_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wbuf_q    <= wbuf_d;
         rbuf_q    <= rbuf_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wbuf_d    = wbuf_q;
      rbuf_d    = rbuf_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      case (state_q)
         IDLE: if (i_write_start || i_read_start) begin
            addr_d = i_addr & ALIGN;
            err_d  = 1'b0;
            cnt_d  = '0;
            if (i_write_start) begin
               state_d   = WR_ADDR_DATA;
               wbuf_d    = i_data_block;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end else begin
               state_d   = RD_ADDR;
               arvalid_d = 1'b1;
            end
         end
         WR_ADDR_DATA: begin
            if (awvalid_q && i_awready) awvalid_d = 1'b0;
            // the write line is shifted out so the current beat always sits in the low word
            if (wvalid_q && i_wready) begin
               wbuf_d = wbuf_q >> AXI_DATA_W;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == LAST) wvalid_d = 1'b0;
            end
            if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
         end
         WR_RESP: if (i_bvalid) begin
            err_d   = err_q | (i_bresp != 2'b00);
            state_d = DONE;
         end
         RD_ADDR: if (i_arready) begin
            arvalid_d = 1'b0;
            state_d   = RD_DATA;
         end
         RD_DATA: if (i_rvalid) begin
            rbuf_d[cnt_q*AXI_DATA_W +: AXI_DATA_W] = i_rdata;
            // a misplaced RLAST is flagged but the burst is still counted out to BEATS
            err_d = err_q | (i_rresp != 2'b00) | (i_rlast != (cnt_q == LAST));
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_awid       = '0;
   assign o_awaddr     = addr_q;
   assign o_awlen      = 8'(BEATS - 1);
   assign o_awsize     = 3'($clog2(AXI_DATA_W / 8));
   assign o_awburst    = 2'b01;
   assign o_awvalid    = awvalid_q;
   assign o_wdata      = wbuf_q[AXI_DATA_W-1:0];
   assign o_wstrb      = '1;
   assign o_wlast      = wvalid_q && (cnt_q == LAST);
   assign o_wvalid     = wvalid_q;
   assign o_bready     = state_q == WR_RESP;
   assign o_arid       = '0;
   assign o_araddr     = addr_q;
   assign o_arlen      = 8'(BEATS - 1);
   assign o_arsize     = 3'($clog2(AXI_DATA_W / 8));
   assign o_arburst    = 2'b01;
   assign o_arvalid    = arvalid_q;
   assign o_rready     = state_q == RD_DATA;
   assign o_data_block = rbuf_q;
   assign o_done       = state_q == DONE;
   assign o_error      = o_done && err_q;
endmodule
